// File: rtl/ldq_ctrl_pkg.sv
// Shared load-queue constants and the occupancy-update helper.
package ldq_ctrl_pkg;

   localparam int LDQ_DEPTH = 16;
   localparam int LDQ_INDEX = 4;
   localparam int LDQ_WIDTH = 8;

   // How the occupancy counter moves in a given cycle.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_INC  = 2'b01,
      CNT_DEC  = 2'b10
   } cnt_op_e;

   // An allocation and a retirement in the same cycle cancel out.
   function automatic cnt_op_e cnt_op(input logic alloc, input logic commit);
      cnt_op_e op;
      case ({alloc, commit})
         2'b10:   op = CNT_INC;
         2'b01:   op = CNT_DEC;
         default: op = CNT_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ldq_ctrl_if.sv
// Load-queue control bus: allocation, execution, commit, flush and the
// external payload RAM ports. The core drives it as master, the queue is slave.
interface ldq_ctrl_if
   import ldq_ctrl_pkg::*;
#(
   parameter int INDEX = LDQ_INDEX,
   parameter int WIDTH = LDQ_WIDTH
);
   logic             allocReq_i;
   logic [WIDTH-1:0] allocData_i;
   logic             allocReady_o;
   logic [INDEX-1:0] allocIdx_o;
   logic             exec_i;
   logic [INDEX-1:0] execIdx_i;
   logic             commitValid_o;
   logic [INDEX-1:0] commitIdx_o;
   logic             commit_i;
   logic             flush_i;
   logic [INDEX:0]   count_o;
   logic             ramWe_o;
   logic [INDEX-1:0] ramWrAddr_o;
   logic [WIDTH-1:0] ramWrData_o;
   logic [INDEX-1:0] ramRdAddr_o;

   modport master (
      output allocReq_i, allocData_i, exec_i, execIdx_i, commit_i, flush_i,
      input  allocReady_o, allocIdx_o, commitValid_o, commitIdx_o, count_o,
             ramWe_o, ramWrAddr_o, ramWrData_o, ramRdAddr_o
   );

   modport slave (
      input  allocReq_i, allocData_i, exec_i, execIdx_i, commit_i, flush_i,
      output allocReady_o, allocIdx_o, commitValid_o, commitIdx_o, count_o,
             ramWe_o, ramWrAddr_o, ramWrData_o, ramRdAddr_o
   );
endinterface

// File: rtl/ldq_ptr_cnt.sv
// Wrapping queue pointer: clears to zero, otherwise steps by one on inc.
// Wrap from DEPTH-1 to 0 falls out of the natural INDEX-bit overflow.
module ldq_ptr_cnt
   import ldq_ctrl_pkg::*;
#(
   parameter int INDEX = LDQ_INDEX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [INDEX-1:0] ptr
);
   logic [INDEX-1:0] ptr_r;

   // Pointer register: reset and clear dominate, then increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (clr) begin
         ptr_r <= '0;
      end else if (inc) begin
         ptr_r <= ptr_r + INDEX'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;
endmodule

// File: rtl/ldq_ctrl.sv
// Load-queue controller: tracks head/tail/occupancy and per-entry valid/done
// state. Payloads live in an external RAM written at the tail and read at head.
module ldq_ctrl
   import ldq_ctrl_pkg::*;
#(
   parameter int DEPTH = LDQ_DEPTH,
   parameter int INDEX = LDQ_INDEX,
   parameter int WIDTH = LDQ_WIDTH
) (
   input logic       clk,
   input logic       reset,
   ldq_ctrl_if.slave bus
);
   localparam int CW = INDEX + 1;

   logic [INDEX-1:0] head_ptr_s;
   logic [INDEX-1:0] tail_ptr_s;
   logic [CW-1:0]    count_r;
   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] done_r;
   logic [DEPTH-1:0] valid_nxt_s;
   logic [DEPTH-1:0] done_nxt_s;
   logic             ready_s;
   logic             commit_valid_s;
   logic             alloc_acc_s;
   logic             exec_acc_s;
   logic             commit_acc_s;
   cnt_op_e          cnt_op_s;

   // Readiness looks only at the registered count, so a same-cycle commit
   // never frees a slot for a same-cycle allocation.
   assign ready_s        = (count_r < CW'(DEPTH));
   assign commit_valid_s = (count_r != CW'(0)) && done_r[head_ptr_s];

   assign alloc_acc_s  = bus.allocReq_i && ready_s && !bus.flush_i;
   assign exec_acc_s   = bus.exec_i && !bus.flush_i && valid_r[bus.execIdx_i];
   assign commit_acc_s = bus.commit_i && commit_valid_s && !bus.flush_i;
   assign cnt_op_s     = cnt_op(alloc_acc_s, commit_acc_s);

   ldq_ptr_cnt #(.INDEX(INDEX)) u_head (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.flush_i),
      .inc   (commit_acc_s),
      .ptr   (head_ptr_s)
   );

   ldq_ptr_cnt #(.INDEX(INDEX)) u_tail (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.flush_i),
      .inc   (alloc_acc_s),
      .ptr   (tail_ptr_s)
   );

   // Next per-entry state: alloc sets valid and clears done (winning over exec
   // on the same slot), exec sets done, commit clears both at head.
   always_comb begin
      valid_nxt_s = valid_r;
      done_nxt_s  = done_r;
      for (int i = 0; i < DEPTH; i++) begin
         valid_nxt_s[i] = (valid_r[i] && !(commit_acc_s && head_ptr_s == INDEX'(i)))
                        || (alloc_acc_s && tail_ptr_s == INDEX'(i));
         done_nxt_s[i]  = (done_r[i] || (exec_acc_s && bus.execIdx_i == INDEX'(i)))
                        && !(alloc_acc_s && tail_ptr_s == INDEX'(i))
                        && !(commit_acc_s && head_ptr_s == INDEX'(i));
      end
   end

   // Entry state registers; reset and flush wipe every entry.
   always_ff @(posedge clk) begin
      if (reset || bus.flush_i) begin
         valid_r <= '0;
         done_r  <= '0;
      end else begin
         valid_r <= valid_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Occupancy counter; accepted alloc/commit are already gated by full/empty.
   always_ff @(posedge clk) begin
      if (reset || bus.flush_i) begin
         count_r <= '0;
      end else begin
         case (cnt_op_s)
            CNT_INC: count_r <= count_r + CW'(1);
            CNT_DEC: count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign bus.allocReady_o  = ready_s;
   assign bus.allocIdx_o    = tail_ptr_s;
   assign bus.commitValid_o = commit_valid_s;
   assign bus.commitIdx_o   = head_ptr_s;
   assign bus.ramRdAddr_o   = head_ptr_s;
   assign bus.count_o       = count_r;
   assign bus.ramWe_o       = alloc_acc_s;
   assign bus.ramWrAddr_o   = tail_ptr_s;
   assign bus.ramWrData_o   = bus.allocData_i;
endmodule

// File: tb/tb_ldq_ctrl.sv
// Self-checking bench for ldq_ctrl: a directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_ldq_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ldq_ctrl_if #(.INDEX(4), .WIDTH(8)) bus ();

   ldq_ctrl u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model: ordered list of occupied entries plus the tail index.
   typedef struct {
      int idx;
      bit done;
   } ent_t;
   ent_t m_q[$];
   int   m_tail = 0;
   bit   m_known = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_head();
      return (m_tail - m_q.size() + 16) % 16;
   endfunction

   task automatic model_check();
      bit exp_cv;
      bit exp_we;
      exp_cv = (m_q.size() > 0) && m_q[0].done;
      exp_we = bus.allocReq_i && (m_q.size() < 16) && !bus.flush_i;
      chk("m_ready", 32'(bus.allocReady_o), 32'(m_q.size() < 16));
      chk("m_aidx",  32'(bus.allocIdx_o), 32'(m_tail));
      chk("m_cv",    32'(bus.commitValid_o), 32'(exp_cv));
      chk("m_cidx",  32'(bus.commitIdx_o), 32'(m_head()));
      chk("m_rdaddr", 32'(bus.ramRdAddr_o), 32'(m_head()));
      chk("m_count", 32'(bus.count_o), 32'(m_q.size()));
      chk("m_we",    32'(bus.ramWe_o), 32'(exp_we));
      if (exp_we) begin
         chk("m_waddr", 32'(bus.ramWrAddr_o), 32'(m_tail));
         chk("m_wdata", 32'(bus.ramWrData_o), 32'(bus.allocData_i));
      end
   endtask

   task automatic model_update();
      bit a;
      bit c;
      if (reset || bus.flush_i) begin
         m_q.delete();
         m_tail  = 0;
         m_known = 1'b1;
      end else begin
         a = bus.allocReq_i && (m_q.size() < 16);
         c = bus.commit_i && (m_q.size() > 0) && m_q[0].done;
         if (bus.exec_i) begin
            foreach (m_q[k]) if (m_q[k].idx == int'(bus.execIdx_i)) m_q[k].done = 1'b1;
         end
         if (c) void'(m_q.pop_front());
         if (a) begin
            m_q.push_back('{idx: m_tail, done: 1'b0});
            m_tail = (m_tail + 1) % 16;
         end
      end
   endtask

   // Apply inputs, then sample outputs on the falling edge.
   task automatic drive(input logic r, input logic a, input logic [7:0] d, input logic e,
                        input logic [3:0] ei, input logic c, input logic f);
      reset           = r;
      bus.allocReq_i  = a;
      bus.allocData_i = d;
      bus.exec_i      = e;
      bus.execIdx_i   = ei;
      bus.commit_i    = c;
      bus.flush_i     = f;
      @(negedge clk);
      if (m_known) model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic alloc_n(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, base + 8'(i), 1'b0, 4'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic exec1(input logic [3:0] idx);
      drive(1'b0, 1'b0, 8'h00, 1'b1, idx, 1'b0, 1'b0);
      tick();
   endtask

   typedef struct {
      logic       rst, alloc;
      logic [7:0] data;
      logic       ex;
      logic [3:0] eidx;
      logic       cm, fl;
      logic       e_ready, e_we;
      logic [3:0] e_aidx;
      logic       e_cv;
      logic [3:0] e_cidx;
      logic [4:0] e_cnt;
   } vec_t;
   vec_t tbl[16];

   initial begin
      reset = 1'b1;
      bus.allocReq_i = 1'b0; bus.allocData_i = 8'h00; bus.exec_i = 1'b0;
      bus.execIdx_i = 4'd0; bus.commit_i = 1'b0; bus.flush_i = 1'b0;

      //            rst  alloc data   ex   eidx  cm   fl   rdy  we   aidx  cv   cidx  cnt
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0};
      tbl[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0};
      tbl[2]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 5'd1};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 5'd2};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 5'd2};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 5'd2};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 4'd0, 5'd2};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 5'd1};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 5'd1};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd2, 5'd0};
      tbl[10] = '{1'b0, 1'b1, 8'hA3, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd2, 5'd0};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd2, 5'd1};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd2, 5'd1};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd2, 5'd1};
      tbl[14] = '{1'b0, 1'b1, 8'hA4, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 4'd2, 5'd1};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0};

      // Directed vector table from the reset state.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         drive(tbl[k].rst, tbl[k].alloc, tbl[k].data, tbl[k].ex, tbl[k].eidx, tbl[k].cm, tbl[k].fl);
         chk($sformatf("tbl%0d_ready", k), 32'(bus.allocReady_o), 32'(tbl[k].e_ready));
         chk($sformatf("tbl%0d_we", k),    32'(bus.ramWe_o), 32'(tbl[k].e_we));
         chk($sformatf("tbl%0d_aidx", k),  32'(bus.allocIdx_o), 32'(tbl[k].e_aidx));
         chk($sformatf("tbl%0d_cv", k),    32'(bus.commitValid_o), 32'(tbl[k].e_cv));
         chk($sformatf("tbl%0d_cidx", k),  32'(bus.commitIdx_o), 32'(tbl[k].e_cidx));
         chk($sformatf("tbl%0d_cnt", k),   32'(bus.count_o), 32'(tbl[k].e_cnt));
         if (tbl[k].e_we) begin
            chk($sformatf("tbl%0d_waddr", k), 32'(bus.ramWrAddr_o), 32'(tbl[k].e_aidx));
            chk($sformatf("tbl%0d_wdata", k), 32'(bus.ramWrData_o), 32'(tbl[k].data));
         end
         tick();
      end

      // Fill to 16 with 0x10..0x1F, then a 17th request is refused.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, 4'd0, 1'b0, 1'b0);
         chk("fill_we", 32'(bus.ramWe_o), 32'd1);
         chk("fill_waddr", 32'(bus.ramWrAddr_o), 32'(i));
         chk("fill_wdata", 32'(bus.ramWrData_o), 32'h10 + 32'(i));
         tick();
      end
      drive(1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("full_count", 32'(bus.count_o), 32'd16);
      chk("full_ready", 32'(bus.allocReady_o), 32'd0);
      chk("full_we", 32'(bus.ramWe_o), 32'd0);
      tick();

      // Out-of-order exec: head not done until idx 0 executes.
      exec1(4'd1);
      idle();
      chk("exec1_cv", 32'(bus.commitValid_o), 32'd0);
      tick();
      exec1(4'd0);
      idle();
      chk("exec0_cv", 32'(bus.commitValid_o), 32'd1);
      chk("exec0_cidx", 32'(bus.commitIdx_o), 32'd0);
      tick();

      // Full queue: alloc+commit together -> alloc refused, commit taken.
      drive(1'b0, 1'b1, 8'h20, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("fullac_we", 32'(bus.ramWe_o), 32'd0);
      tick();
      drive(1'b0, 1'b1, 8'h20, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("fullac_count", 32'(bus.count_o), 32'd15);
      chk("commit_head", 32'(bus.commitIdx_o), 32'd1);
      chk("commit_cv", 32'(bus.commitValid_o), 32'd1);
      chk("wrap_we", 32'(bus.ramWe_o), 32'd1);
      chk("wrap_waddr", 32'(bus.ramWrAddr_o), 32'd0);
      tick();
      idle();
      chk("wrap_count", 32'(bus.count_o), 32'd16);
      chk("wrap_aidx", 32'(bus.allocIdx_o), 32'd1);
      tick();

      // Count 5: simultaneous alloc+commit keeps count, moves both pointers.
      do_reset();
      alloc_n(5, 8'h30);
      for (int i = 0; i < 5; i++) exec1(4'(i));
      drive(1'b0, 1'b1, 8'h40, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("ac5_cv", 32'(bus.commitValid_o), 32'd1);
      chk("ac5_we", 32'(bus.ramWe_o), 32'd1);
      tick();
      idle();
      chk("ac5_count", 32'(bus.count_o), 32'd5);
      chk("ac5_head", 32'(bus.commitIdx_o), 32'd1);
      chk("ac5_tail", 32'(bus.allocIdx_o), 32'd6);
      tick();

      // Flush at count 9 beats alloc, exec and commit.
      do_reset();
      alloc_n(9, 8'h50);
      exec1(4'd0);
      drive(1'b0, 1'b1, 8'h66, 1'b1, 4'd3, 1'b1, 1'b1);
      chk("flush_we", 32'(bus.ramWe_o), 32'd0);
      tick();
      idle();
      chk("flush_count", 32'(bus.count_o), 32'd0);
      chk("flush_aidx", 32'(bus.allocIdx_o), 32'd0);
      chk("flush_cv", 32'(bus.commitValid_o), 32'd0);
      chk("flush_cidx", 32'(bus.commitIdx_o), 32'd0);
      tick();

      // Reset mid-operation at count 7 with an alloc pending.
      alloc_n(7, 8'h70);
      exec1(4'd0);
      drive(1'b1, 1'b1, 8'h77, 1'b1, 4'd1, 1'b1, 1'b0);
      tick();
      idle();
      chk("rst_ready", 32'(bus.allocReady_o), 32'd1);
      chk("rst_aidx", 32'(bus.allocIdx_o), 32'd0);
      chk("rst_cv", 32'(bus.commitValid_o), 32'd0);
      chk("rst_cidx", 32'(bus.commitIdx_o), 32'd0);
      chk("rst_count", 32'(bus.count_o), 32'd0);
      chk("rst_we", 32'(bus.ramWe_o), 32'd0);
      tick();

      // Randomized traffic checked against the queue model every cycle.
      for (int n = 0; n < 3000; n++) begin
         drive(1'($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 99) < 55),
               8'($urandom),
               1'($urandom_range(0, 99) < 60),
               4'($urandom),
               1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 2));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ldq_ctrl.md
LDQ_CTRL -- requirements
Module: ldq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of load-queue entries (power of two).
REQ-002 SHALL have parameter INDEX, default 4, log2(DEPTH).
REQ-003 SHALL have parameter WIDTH, default 8, entry payload width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port allocReq_i  in  1  request to allocate one entry at tail.
REQ-007 SHALL have port allocData_i  in  WIDTH  payload of allocated entry.
REQ-008 SHALL have port allocReady_o  out  1  queue can accept an allocation.
REQ-009 SHALL have port allocIdx_o  out  INDEX  index the next allocation receives (tail).
REQ-010 SHALL have port exec_i  in  1  mark an entry executed.
REQ-011 SHALL have port execIdx_i  in  INDEX  entry to mark executed.
REQ-012 SHALL have port commitValid_o  out  1  head entry valid and executed.
REQ-013 SHALL have port commitIdx_o  out  INDEX  head index.
REQ-014 SHALL have port commit_i  in  1  retire head entry.
REQ-015 SHALL have port flush_i  in  1  discard all entries.
REQ-016 SHALL have port count_o  out  INDEX+1  occupied entries.
REQ-017 SHALL have ports ramWe_o (out, 1), ramWrAddr_o (out, INDEX), ramWrData_o (out, WIDTH) driving the external 1W storage RAM write port.
REQ-018 SHALL have port ramRdAddr_o  out  INDEX  read address for head payload on the external RAM.

Function
REQ-019 SHALL hold registered headPtr, tailPtr (INDEX bits, wrap modulo DEPTH), count (INDEX+1 bits), per-entry valid and done bits.
REQ-020 SHALL drive allocReady_o = (count < DEPTH), combinational from registered count only; no same-cycle commit bypass.
REQ-021 SHALL accept an allocation when allocReq_i & allocReady_o & ~flush_i: ramWe_o=1, ramWrAddr_o=tailPtr, ramWrData_o=allocData_i same cycle; next cycle valid[tail]=1, done[tail]=0, tailPtr+1.
REQ-022 SHALL hold ramWe_o=0 when no allocation is accepted; allocReq_i while full is ignored with no state change.
REQ-023 SHALL on exec_i & ~flush_i set done[execIdx_i] next cycle only if valid[execIdx_i]=1; else ignore.
REQ-024 SHALL, when alloc and exec target the same index in one cycle, let alloc win (done=0).
REQ-025 SHALL drive commitValid_o = (count != 0) & done[headPtr]; commitIdx_o = ramRdAddr_o = headPtr.
REQ-026 SHALL accept commit when commit_i & commitValid_o & ~flush_i: next cycle valid[head]=0, done[head]=0, headPtr+1; commit_i without commitValid_o is ignored.
REQ-027 SHALL, on simultaneous accepted alloc and commit, leave count unchanged and advance both pointers.
REQ-028 SHALL wrap pointers from DEPTH-1 to 0.
REQ-029 SHALL give flush_i priority over alloc, exec, commit: next cycle headPtr=tailPtr=0, count=0, all valid/done=0; ramWe_o=0 in the flush cycle.
REQ-030 SHALL keep count_o = registered count; count never exceeds DEPTH nor underflows.

Reset
REQ-031 SHALL on reset at a clock edge set headPtr=tailPtr=0, count=0, all valid/done=0, regardless of other inputs, including mid-operation.
REQ-032 SHALL yield after reset: allocReady_o=1, allocIdx_o=0, commitValid_o=0, commitIdx_o=0, count_o=0, ramWe_o=0 (absent alloc request).

Structure
REQ-033 SHALL take LDQ_DEPTH, LDQ_INDEX, LDQ_WIDTH constants from the shared core package; no local typedefs duplicating them.
REQ-034 SHALL use one sub-module ldq_ptr_cnt (INDEX-bit wrapping pointer with increment and clear), instantiated for head and tail.
REQ-035 SHALL contain no storage array for payloads; payload lives in the external RAM.

Verification
REQ-036 SHALL cover: reset, 16 allocs data 0x10..0x1F -> ramWrAddr 0..15, count_o=16, allocReady_o=0; 17th request -> ramWe_o=0.
REQ-037 SHALL cover: exec idx 1 only -> commitValid_o=0; exec idx 0 -> next cycle commitValid_o=1, commitIdx_o=0; commit -> head=1, commitValid_o=1 (idx 1 done).
REQ-038 SHALL cover: full queue, same-cycle alloc+commit -> alloc rejected, count_o=15; next cycle alloc accepted at idx 0 (wrap), count_o=16.
REQ-039 SHALL cover: count 5, alloc+commit same cycle -> count_o stays 5, head and tail both +1.
REQ-040 SHALL cover: flush_i with alloc, exec, commit asserted at count 9 -> ramWe_o=0, next cycle count_o=0, allocIdx_o=0, commitValid_o=0.
REQ-041 SHALL cover: reset asserted with alloc pending at count 7 -> next cycle all outputs at REQ-032 values.
